// File: rtl/hs_pkg.sv
// Shared types and elaboration helpers for the round-robin handshake scheduler.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package hs_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Ceiling log2 for sizing counters and indices at elaboration time.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first set request at or above ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_pick
    import hs_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             idx;

    // Rotate a doubled request vector so bit k stands for requester (ptr+k) mod N, then take the lowest.
    always_comb begin
        dbl        = {req, req};
        rot        = N'(dbl >> ptr);
        any        = 1'b0;
        idx        = 0;
        gnt_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !any) begin
                any = 1'b1;
                idx = (int'(ptr) + k) % N;
            end
        end
        gnt_idx = IDW'(idx);
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/handshake_rr_scheduler.sv
// N-way round-robin scheduler onto one credit-gated channel, packets locked until *_last.
// Latency: 1 cycle from input fire to registered out_valid; full register reloads bubble-free.
// Backpressure: in_ready drops when the output register is held or no downstream credit remains.
module handshake_rr_scheduler
    import hs_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int CREDITS = 6,
    parameter int IDW     = 2,
    localparam int CW     = clog2(CREDITS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N-1:0]   in_last,
    input  logic [N*W-1:0] in_payload,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_payload,
    output logic           out_last,
    output logic [IDW-1:0] out_id,
    input  logic           credit_return,
    output logic [CW-1:0]  credit_cnt,
    output logic           credit_err
);

    state_e         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_payload_q, out_payload_d;
    logic           out_last_q, out_last_d;
    logic [IDW-1:0] out_id_q, out_id_d;
    logic [CW-1:0]  credit_cnt_q, credit_cnt_d;
    logic           credit_err_q, credit_err_d;

    logic [N-1:0]   gnt_onehot;
    logic [IDW-1:0] gnt_idx;
    logic           any;
    logic           load_en;
    logic           fire;
    logic [IDW-1:0] sel_idx;
    logic [IDW-1:0] nxt_ptr;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req        (in_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // Grant/lock selection, output register loading and credit accounting.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        out_valid_d   = out_valid_q;
        out_payload_d = out_payload_q;
        out_last_d    = out_last_q;
        out_id_d      = out_id_q;
        credit_cnt_d  = credit_cnt_q;
        credit_err_d  = credit_err_q;
        in_ready      = '0;

        load_en = (!out_valid_q || out_ready) && (credit_cnt_q != '0);
        sel_idx = (state_q == LOCKED) ? owner_q : gnt_idx;
        nxt_ptr = (sel_idx == IDW'(N - 1)) ? '0 : sel_idx + 1'b1;

        // A locked owner keeps in_ready even while it idles, so a stalled packet cannot be preempted.
        if (load_en) begin
            if (state_q == LOCKED) begin
                in_ready[owner_q] = 1'b1;
            end else if (any) begin
                in_ready = gnt_onehot;
            end
        end
        fire = |(in_valid & in_ready);

        if (fire) begin
            if (in_last[sel_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = nxt_ptr;
            end else begin
                state_d = LOCKED;
                owner_d = sel_idx;
            end
            out_valid_d   = 1'b1;
            out_payload_d = in_payload[sel_idx*W +: W];
            out_last_d    = in_last[sel_idx];
            out_id_d      = sel_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A fire and a return in the same cycle cancel; a surplus return saturates and flags.
        if (fire && !credit_return) begin
            credit_cnt_d = credit_cnt_q - 1'b1;
        end else if (!fire && credit_return) begin
            if (credit_cnt_q == CW'(CREDITS)) begin
                credit_err_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + 1'b1;
            end
        end
    end

    // State, output register and credit counter; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
            out_last_q    <= 1'b0;
            out_id_q      <= '0;
            credit_cnt_q  <= CW'(CREDITS);
            credit_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
            out_last_q    <= out_last_d;
            out_id_q      <= out_id_d;
            credit_cnt_q  <= credit_cnt_d;
            credit_err_q  <= credit_err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_payload = out_payload_q;
    assign out_last    = out_last_q;
    assign out_id      = out_id_q;
    assign credit_cnt  = credit_cnt_q;
    assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_handshake_rr_scheduler.sv
// Self-checking bench for handshake_rr_scheduler: directed table, corner sequences, random vs model.
// Latency: inputs driven 2 time units after the rising edge, comb outputs sampled 1 unit later.
// Backpressure: out_ready and credit_return are driven by the bench.
module tb_handshake_rr_scheduler;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int CREDITS = 6;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   in_last;
    logic [N*W-1:0] in_payload;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_payload;
    logic           out_last;
    logic [1:0]     out_id;
    logic           credit_return;
    logic [2:0]     credit_cnt;
    logic           credit_err;

    int checks = 0;
    int errors = 0;

    handshake_rr_scheduler #(.N(N), .W(W), .CREDITS(CREDITS), .IDW(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last       (in_last),
        .in_payload    (in_payload),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_payload   (out_payload),
        .out_last      (out_last),
        .out_id        (out_id),
        .credit_return (credit_return),
        .credit_cnt    (credit_cnt),
        .credit_err    (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       ordy;
        logic       cret;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_id;
        logic       e_last;
        int         e_cnt;
        logic       e_err;
    } vec_t;

    vec_t       tbl [20];
    logic [7:0] pat [4];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic o, input logic c,
                                input logic [3:0] er, input logic eov, input logic [1:0] eid,
                                input logic el, input int ec, input logic ee);
        vec_t r;
        r.vld = v; r.lst = l; r.ordy = o; r.cret = c;
        r.e_rdy = er; r.e_ov = eov; r.e_id = eid; r.e_last = el; r.e_cnt = ec; r.e_err = ee;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic o, input logic c);
        in_valid      = v;
        in_last       = l;
        out_ready     = o;
        credit_return = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        in_valid      = '0;
        in_last       = '0;
        out_ready     = 1'b0;
        credit_return = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Behavioural reference: owner < 0 means no packet in progress.
    int         m_owner;
    int         m_rr;
    int         m_cred;
    logic       m_err;
    logic       m_ov;
    logic [7:0] m_op;
    logic       m_ol;
    int         m_oid;

    task automatic model_init();
        m_owner = -1; m_rr = 0; m_cred = CREDITS; m_err = 1'b0;
        m_ov = 1'b0; m_op = 8'h00; m_ol = 1'b0; m_oid = 0;
    endtask

    initial begin
        int fires;
        logic pend;
        logic [3:0] rdy_exp;

        pat[0] = 8'hA0; pat[1] = 8'hB1; pat[2] = 8'hC2; pat[3] = 8'hD3;
        in_payload = {pat[3], pat[2], pat[1], pat[0]};

        tbl[0]  = mk(4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0, 6, 0);
        tbl[1]  = mk(4'b0011, 4'b0011, 1, 0, 4'b0001, 1, 2'd0, 1, 5, 0);
        tbl[2]  = mk(4'b0111, 4'b0000, 1, 1, 4'b0010, 1, 2'd1, 0, 5, 0);
        tbl[3]  = mk(4'b0111, 4'b0000, 1, 0, 4'b0010, 1, 2'd1, 0, 4, 0);
        tbl[4]  = mk(4'b0111, 4'b0010, 1, 0, 4'b0010, 1, 2'd1, 1, 3, 0);
        tbl[5]  = mk(4'b0101, 4'b0101, 1, 0, 4'b0100, 1, 2'd2, 1, 2, 0);
        tbl[6]  = mk(4'b0001, 4'b0001, 1, 0, 4'b0001, 1, 2'd0, 1, 1, 0);
        tbl[7]  = mk(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 1, 2, 0);
        tbl[8]  = mk(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 1, 3, 0);
        tbl[9]  = mk(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 1, 4, 0);
        tbl[10] = mk(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 1, 5, 0);
        tbl[11] = mk(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 1, 6, 0);
        tbl[12] = mk(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 1, 6, 1);
        tbl[13] = mk(4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 1, 6, 1);
        tbl[14] = mk(4'b0100, 4'b0000, 1, 0, 4'b0100, 1, 2'd2, 0, 5, 1);
        tbl[15] = mk(4'b0011, 4'b0000, 1, 0, 4'b0100, 0, 2'd2, 0, 5, 1);
        tbl[16] = mk(4'b0111, 4'b0100, 1, 0, 4'b0100, 1, 2'd2, 1, 4, 1);
        tbl[17] = mk(4'b1011, 4'b1011, 1, 0, 4'b1000, 1, 2'd3, 1, 3, 1);
        tbl[18] = mk(4'b0011, 4'b0011, 0, 0, 4'b0000, 1, 2'd3, 1, 3, 1);
        tbl[19] = mk(4'b0011, 4'b0011, 1, 0, 4'b0001, 1, 2'd0, 1, 2, 1);

        // T1: set the sticky error, open a packet on req2, then reset mid-packet.
        do_reset();
        drive(4'b0000, 4'b0000, 1, 1);
        tick();
        chk("pre_err_set", 32'(credit_err), 32'd1);
        drive(4'b0100, 4'b0000, 1, 0);
        tick();
        chk("pre_lock_ov", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ov", 32'(out_valid), 32'd0);
        chk("rst_async_cnt", 32'(credit_cnt), 32'd6);
        chk("rst_async_err", 32'(credit_err), 32'd0);
        do_reset();

        // Directed table: lowest-index first grant, lock, same-cycle fire+return, surplus return, stall.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].vld, tbl[i].lst, tbl[i].ordy, tbl[i].cret);
            chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            tick();
            chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_id", i), 32'(out_id), 32'(tbl[i].e_id));
            chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].e_last));
            chk($sformatf("tbl%0d_cnt", i), 32'(credit_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_err", i), 32'(credit_err), 32'(tbl[i].e_err));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_pay", i), 32'(out_payload), 32'(pat[tbl[i].e_id]));
            end
        end

        // T2: fairness with credit loopback one cycle after each output fire.
        do_reset();
        pend = 1'b0;
        for (int k = 0; k < 12; k++) begin
            credit_return = pend;
            pend = out_valid;
            drive(4'b1111, 4'b1111, 1, credit_return);
            tick();
            chk($sformatf("fair%0d_ov", k), 32'(out_valid), 32'd1);
            chk($sformatf("fair%0d_id", k), 32'(out_id), 32'(k % 4));
        end

        // T4: credits exhaust after exactly six beats; one return lets exactly one more through.
        do_reset();
        fires = 0;
        for (int k = 0; k < 10; k++) begin
            drive(4'b1111, 4'b1111, 1, 0);
            fires += $countones(in_valid & in_ready);
            tick();
        end
        chk("cred_fires", 32'(fires), 32'd6);
        chk("cred_cnt0", 32'(credit_cnt), 32'd0);
        drive(4'b1111, 4'b1111, 1, 0);
        chk("cred_rdy0", 32'(in_ready), 32'd0);
        fires = 0;
        drive(4'b1111, 4'b1111, 1, 1);
        fires += $countones(in_valid & in_ready);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 4'b1111, 1, 0);
            fires += $countones(in_valid & in_ready);
            tick();
        end
        chk("cred_refire", 32'(fires), 32'd1);
        chk("cred_cnt_end", 32'(credit_cnt), 32'd0);

        // T5: output held under backpressure; inputs change underneath.
        do_reset();
        drive(4'b0001, 4'b0001, 0, 0);
        tick();
        in_payload = 32'h5566_7788;
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 4'b1111, 0, 0);
            chk($sformatf("bp%0d_rdy", k), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("bp%0d_ov", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_pay", k), 32'(out_payload), 32'hA0);
            chk($sformatf("bp%0d_id", k), 32'(out_id), 32'd0);
            chk($sformatf("bp%0d_last", k), 32'(out_last), 32'd1);
            chk($sformatf("bp%0d_cnt", k), 32'(credit_cnt), 32'd5);
        end
        drive(4'b1111, 4'b1111, 1, 0);
        tick();
        chk("bp_release_id", 32'(out_id), 32'd1);
        chk("bp_release_pay", 32'(out_payload), 32'h77);

        // Random traffic against the behavioural model.
        do_reset();
        model_init();
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] v;
            logic [3:0] l;
            logic       o;
            logic       r;
            int         cand;
            logic       mload;
            logic       mfire;
            v = 4'($urandom_range(0, 15) & $urandom_range(0, 15) | $urandom_range(0, 15));
            l = 4'($urandom);
            o = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 3);
            in_payload = $urandom;

            mload = (!m_ov || o) && (m_cred > 0);
            cand = m_owner;
            if (cand < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (cand < 0 && v[(m_rr + k) % N]) cand = (m_rr + k) % N;
                end
            end
            rdy_exp = (cand >= 0 && mload) ? 4'(1 << cand) : 4'b0000;
            mfire = (rdy_exp != 4'b0000) && v[cand];

            drive(v, l, o, r);
            chk($sformatf("rnd%0d_rdy", c), 32'(in_ready), 32'(rdy_exp));

            if (mfire) begin
                m_ov = 1'b1;
                m_op = in_payload[cand*8 +: 8];
                m_ol = l[cand];
                m_oid = cand;
                if (l[cand]) begin
                    m_owner = -1;
                    m_rr = (cand + 1) % N;
                end else begin
                    m_owner = cand;
                end
            end else if (o) begin
                m_ov = 1'b0;
            end
            if (mfire && !r) begin
                m_cred = m_cred - 1;
            end else if (!mfire && r) begin
                if (m_cred == CREDITS) m_err = 1'b1;
                else m_cred = m_cred + 1;
            end

            tick();
            chk($sformatf("rnd%0d_ov", c), 32'(out_valid), 32'(m_ov));
            chk($sformatf("rnd%0d_cnt", c), 32'(credit_cnt), 32'(m_cred));
            chk($sformatf("rnd%0d_err", c), 32'(credit_err), 32'(m_err));
            if (m_ov) begin
                chk($sformatf("rnd%0d_pay", c), 32'(out_payload), 32'(m_op));
                chk($sformatf("rnd%0d_last", c), 32'(out_last), 32'(m_ol));
                chk($sformatf("rnd%0d_id", c), 32'(out_id), 32'(m_oid));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
